// File: rtl/fsm_control.sv
// fsm_control: multi-cycle processor control unit.
// Walks each instruction through IF / ID / EX / MEM / WB / BR. All datapath
// controls are decoded combinationally from the current state and the
// instruction register. Only the state and the retired-instruction counter are
// held in flops.

module fsm_control (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic        Instr_Valid,
    input  logic        ALU_zero,
    input  logic        Mem_Ack,
    output logic        IR_LdEn,
    output logic        PC_LdEn,
    output logic        PC_sel,
    output logic        RF_WrEn,
    output logic        RF_WrData_sel,
    output logic        RF_B_sel,
    output logic        ALU_Bin_sel,
    output logic        ALU_Ain_zero,
    output logic [3:0]  ALU_func,
    output logic        MEM_RdEn,
    output logic        MEM_WrEn,
    output logic [31:0] Retired,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_IF  = 4'd0,
        S_ID  = 4'd1,
        S_EX  = 4'd2,
        S_MEM = 4'd3,
        S_WB  = 4'd4,
        S_BR  = 4'd5
    } state_t;

    typedef enum logic [2:0] {
        C_NOP,
        C_RTYPE,
        C_ALUI,
        C_LOAD,
        C_STORE,
        C_BCOND,
        C_JUMP
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_ADDI  = 6'b111000;
    localparam logic [5:0] OP_LI    = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_LB    = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SB    = 6'b000111;
    localparam logic [5:0] OP_SW    = 6'b011111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_B     = 6'b111111;

    localparam logic [3:0] FUNC_ADD = 4'b0000;
    localparam logic [3:0] FUNC_SUB = 4'b0001;
    localparam logic [3:0] FUNC_AND = 4'b0010;
    localparam logic [3:0] FUNC_OR  = 4'b0011;

    state_t      state_q, state_d;
    logic [31:0] retired_q, retired_d;

    logic [5:0]  opcode;
    iclass_t     iclass;
    logic        is_li;
    logic        is_bne;

    // ALU-side controls derived from the instruction alone; EX drives them
    // and MEM/WB keep driving them so the ALU result stays stable.
    logic        dec_rf_b_sel;
    logic        dec_alu_bin_sel;
    logic        dec_alu_ain_zero;
    logic [3:0]  dec_alu_func;

    logic        ir_ld;
    logic        pc_ld;
    logic        pc_sel;
    logic        rf_wr;
    logic        rf_wrdata_sel;
    logic        rf_b_sel;
    logic        alu_bin_sel;
    logic        alu_ain_zero;
    logic [3:0]  alu_func;
    logic        mem_rd;
    logic        mem_wr;

    // Only the opcode and the low func nibble steer control; the rest of the
    // instruction word feeds the datapath directly.
    logic unused_instr_bits;
    assign unused_instr_bits = ^Instr[25:4];

    assign opcode = Instr[31:26];

    // Sort the opcode into the instruction classes that share a state path.
    always_comb begin
        iclass = C_NOP;
        is_li  = 1'b0;
        is_bne = 1'b0;
        case (opcode)
            OP_RTYPE: iclass = C_RTYPE;
            OP_ADDI,
            OP_ANDI,
            OP_ORI:   iclass = C_ALUI;
            OP_LI: begin
                iclass = C_ALUI;
                is_li  = 1'b1;
            end
            OP_LB,
            OP_LW:    iclass = C_LOAD;
            OP_SB,
            OP_SW:    iclass = C_STORE;
            OP_BEQ:   iclass = C_BCOND;
            OP_BNE: begin
                iclass = C_BCOND;
                is_bne = 1'b1;
            end
            OP_B:     iclass = C_JUMP;
            default:  iclass = C_NOP;
        endcase
    end

    // ALU operand and operation selection per instruction class.
    always_comb begin
        dec_rf_b_sel     = 1'b0;
        dec_alu_bin_sel  = 1'b0;
        dec_alu_ain_zero = 1'b0;
        dec_alu_func     = FUNC_ADD;
        case (iclass)
            C_RTYPE: begin
                dec_rf_b_sel    = 1'b0;
                dec_alu_bin_sel = 1'b0;
                dec_alu_func    = Instr[3:0];
            end
            C_ALUI: begin
                dec_alu_bin_sel  = 1'b1;
                dec_alu_ain_zero = is_li;
                if (opcode == OP_ANDI) begin
                    dec_alu_func = FUNC_AND;
                end else if (opcode == OP_ORI) begin
                    dec_alu_func = FUNC_OR;
                end else begin
                    dec_alu_func = FUNC_ADD;
                end
            end
            C_LOAD: begin
                dec_alu_bin_sel = 1'b1;
                dec_alu_func    = FUNC_ADD;
            end
            C_STORE: begin
                dec_rf_b_sel    = 1'b1;
                dec_alu_bin_sel = 1'b1;
                dec_alu_func    = FUNC_ADD;
            end
            C_BCOND: begin
                dec_rf_b_sel    = 1'b1;
                dec_alu_bin_sel = 1'b0;
                dec_alu_func    = FUNC_SUB;
            end
            default: begin
                dec_rf_b_sel     = 1'b0;
                dec_alu_bin_sel  = 1'b0;
                dec_alu_ain_zero = 1'b0;
                dec_alu_func     = FUNC_ADD;
            end
        endcase
    end

    // Next-state and per-state control outputs; PC_LdEn marks the last cycle
    // of every instruction and is also what advances the retired counter.
    always_comb begin
        state_d       = S_IF;
        ir_ld         = 1'b0;
        pc_ld         = 1'b0;
        pc_sel        = 1'b0;
        rf_wr         = 1'b0;
        rf_wrdata_sel = 1'b0;
        rf_b_sel      = 1'b0;
        alu_bin_sel   = 1'b0;
        alu_ain_zero  = 1'b0;
        alu_func      = FUNC_ADD;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        case (state_q)
            S_IF: begin
                ir_ld   = Instr_Valid;
                state_d = Instr_Valid ? S_ID : S_IF;
            end
            S_ID: begin
                state_d = (iclass == C_JUMP) ? S_BR : S_EX;
            end
            S_EX: begin
                rf_b_sel     = dec_rf_b_sel;
                alu_bin_sel  = dec_alu_bin_sel;
                alu_ain_zero = dec_alu_ain_zero;
                alu_func     = dec_alu_func;
                case (iclass)
                    C_RTYPE,
                    C_ALUI:  state_d = S_WB;
                    C_LOAD,
                    C_STORE: state_d = S_MEM;
                    C_BCOND: begin
                        pc_ld   = 1'b1;
                        pc_sel  = is_bne ? ~ALU_zero : ALU_zero;
                        state_d = S_IF;
                    end
                    default: begin
                        pc_ld   = 1'b1;
                        pc_sel  = 1'b0;
                        state_d = S_IF;
                    end
                endcase
            end
            S_MEM: begin
                rf_b_sel     = dec_rf_b_sel;
                alu_bin_sel  = dec_alu_bin_sel;
                alu_ain_zero = dec_alu_ain_zero;
                alu_func     = dec_alu_func;
                mem_rd       = (iclass == C_LOAD);
                mem_wr       = (iclass == C_STORE);
                if (!Mem_Ack) begin
                    state_d = S_MEM;
                end else if (iclass == C_LOAD) begin
                    state_d = S_WB;
                end else begin
                    pc_ld   = 1'b1;
                    pc_sel  = 1'b0;
                    state_d = S_IF;
                end
            end
            S_WB: begin
                rf_b_sel      = dec_rf_b_sel;
                alu_bin_sel   = dec_alu_bin_sel;
                alu_ain_zero  = dec_alu_ain_zero;
                alu_func      = dec_alu_func;
                rf_wr         = 1'b1;
                rf_wrdata_sel = (iclass != C_LOAD);
                pc_ld         = 1'b1;
                pc_sel        = 1'b0;
                state_d       = S_IF;
            end
            S_BR: begin
                pc_ld   = 1'b1;
                pc_sel  = 1'b1;
                state_d = S_IF;
            end
            default: begin
                state_d = S_IF;
            end
        endcase
    end

    // Retired count advances on the edge that closes an instruction.
    always_comb begin
        retired_d = retired_q;
        if (pc_ld) begin
            retired_d = retired_q + 32'd1;
        end
    end

    // State and retired counter; reset returns to fetch with a cleared count.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IF;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // IR load depends directly on Instr_Valid, so it is masked while reset
    // is held; every other enable is already idle because the state is IF.
    assign IR_LdEn       = ir_ld & Reset;
    assign PC_LdEn       = pc_ld;
    assign PC_sel        = pc_sel;
    assign RF_WrEn       = rf_wr;
    assign RF_WrData_sel = rf_wrdata_sel;
    assign RF_B_sel      = rf_b_sel;
    assign ALU_Bin_sel   = alu_bin_sel;
    assign ALU_Ain_zero  = alu_ain_zero;
    assign ALU_func      = alu_func;
    assign MEM_RdEn      = mem_rd;
    assign MEM_WrEn      = mem_wr;
    assign Retired       = retired_q;
    assign State         = state_q;

endmodule
